// File: rtl/usb_proto_pkg.sv
// Shared PID encodings and controller state for the multi-endpoint USB protocol controller.
package usb_proto_pkg;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX_DATA = 3'd1,
        RX_OUT  = 3'd2,
        RX_IN   = 3'd3,
        RX_ACK  = 3'd4,
        RX_NAK  = 3'd5,
        RX_BAD  = 3'd6
    } rx_pid_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_DATA = 2'd1,
        TX_ACK  = 2'd2,
        TX_NAK  = 2'd3
    } tx_pid_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OUT_WAIT_DATA,
        ST_OUT_RECV,
        ST_OUT_BAD_WAIT,
        ST_OUT_ACK,
        ST_OUT_ACK_WAIT,
        ST_OUT_DRAIN,
        ST_IN_FILL,
        ST_OUT_SINK,
        ST_IN_SEND,
        ST_IN_STREAM,
        ST_IN_TX_WAIT,
        ST_IN_WAIT_HS,
        ST_NAK_SEND,
        ST_NAK_WAIT
    } state_e;

    // States in which the transmitter owns the bus.
    function automatic logic is_tx_state(input state_e s);
        return (s == ST_OUT_ACK)   || (s == ST_OUT_ACK_WAIT) ||
               (s == ST_IN_SEND)   || (s == ST_IN_STREAM)    ||
               (s == ST_IN_TX_WAIT)|| (s == ST_NAK_SEND)     ||
               (s == ST_NAK_WAIT);
    endfunction

endpackage

// File: rtl/proto_timeout_cnt.sv
// Clear/enable cycle counter; expired is high on the last counted cycle (count == TIMEOUT_CYC-1).
module proto_timeout_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/usb_proto_ctrl_mep.sv
// Multi-endpoint USB OUT/IN protocol controller with per-endpoint DATA0/DATA1 tracking.
// Define USB_PROTO_TIMEOUT_EN to enable the host-response timeout and timeout_error.
module usb_proto_ctrl_mep #(
    parameter int EP_W        = 1,
    parameter int SZ_W        = 7,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic [2:0]      rx_packet,
    input  logic [EP_W-1:0] rx_endpoint,
    input  logic            rx_data_toggle,
    input  logic            tx_done,
    input  logic            buffer_reserved,
    input  logic [EP_W-1:0] tx_ep,
    input  logic [SZ_W-1:0] tx_packet_data_size,
    input  logic [SZ_W-1:0] buffer_occupancy,
    output logic            rx_data_ready,
    output logic            rx_transfer_active,
    output logic            rx_error,
    output logic            tx_transfer_active,
    output logic            tx_error,
    output logic [EP_W-1:0] rx_ep_out,
    output logic            clear,
    output logic [1:0]      tx_packet,
    output logic            tx_data_toggle,
    output logic            d_mode,
    output logic            timeout_error
);
    import usb_proto_pkg::*;

    localparam int NUM_EP = 2 ** EP_W;

    rx_pid_e rx_pid;
    assign rx_pid = rx_pid_e'(rx_packet);

    state_e            state_q, state_d, ret_q, ret_d;
    logic [EP_W-1:0]   cur_ep_q, cur_ep_d;
    logic              tog_q, tog_d;
    logic              discard_q, discard_d;
    logic              sink_data_q, sink_data_d;
    logic [NUM_EP-1:0] out_tog_q, out_tog_d;
    logic [NUM_EP-1:0] in_tog_q, in_tog_d;

    logic              rx_data_ready_q, rx_data_ready_d;
    logic              rx_transfer_active_q, rx_transfer_active_d;
    logic              rx_error_q, rx_error_d;
    logic              tx_transfer_active_q, tx_transfer_active_d;
    logic              tx_error_q, tx_error_d;
    logic [EP_W-1:0]   rx_ep_out_q, rx_ep_out_d;
    logic              clear_q, clear_d;
    tx_pid_e           tx_packet_q, tx_packet_d;
    logic              tx_data_toggle_q, tx_data_toggle_d;
    logic              d_mode_q, d_mode_d;
    logic              timeout_error_q, timeout_error_d;

    logic timeout_hit;

`ifdef USB_PROTO_TIMEOUT_EN
    // Restarts on every state change so each wait state gets a full window.
    proto_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (state_d != state_q),
        .en     ((state_q == ST_OUT_WAIT_DATA) || (state_q == ST_IN_WAIT_HS)),
        .expired(timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        ret_d           = ret_q;
        cur_ep_d        = cur_ep_q;
        tog_d           = tog_q;
        discard_d       = discard_q;
        sink_data_d     = sink_data_q;
        out_tog_d       = out_tog_q;
        in_tog_d        = in_tog_q;
        rx_data_ready_d = rx_data_ready_q;
        rx_ep_out_d     = rx_ep_out_q;
        rx_error_d      = rx_error_q;
        tx_error_d      = tx_error_q;
        timeout_error_d = timeout_error_q;
        clear_d         = 1'b0;

        if (rx_pid == RX_OUT) begin
            rx_data_ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_pid == RX_OUT) begin
                    state_d         = ST_OUT_WAIT_DATA;
                    cur_ep_d        = rx_endpoint;
                    rx_error_d      = 1'b0;
                    tx_error_d      = 1'b0;
                    timeout_error_d = 1'b0;
                end else if (rx_pid == RX_IN) begin
                    state_d  = ST_NAK_SEND;
                    ret_d    = ST_IDLE;
                    cur_ep_d = rx_endpoint;
                end else if (rx_pid == RX_BAD) begin
                    state_d = ST_NAK_SEND;
                    ret_d   = ST_IDLE;
                end else if (buffer_reserved) begin
                    state_d         = ST_IN_FILL;
                    rx_error_d      = 1'b0;
                    tx_error_d      = 1'b0;
                    timeout_error_d = 1'b0;
                end
            end
            ST_OUT_WAIT_DATA: begin
                if (rx_pid == RX_DATA) begin
                    state_d = ST_OUT_RECV;
                    tog_d   = rx_data_toggle;
                end else if (timeout_hit) begin
                    state_d         = ST_IDLE;
                    rx_error_d      = 1'b1;
                    timeout_error_d = 1'b1;
                end
            end
            ST_OUT_RECV: begin
                if (rx_pid == RX_IDLE) begin
                    state_d = ST_OUT_ACK;
                    if (tog_q == out_tog_q[cur_ep_q]) begin
                        rx_data_ready_d     = 1'b1;
                        rx_ep_out_d         = cur_ep_q;
                        out_tog_d[cur_ep_q] = ~out_tog_q[cur_ep_q];
                        discard_d           = 1'b0;
                    end else begin
                        // Host retransmitted data we already ACKed: ACK again, drop payload.
                        clear_d   = 1'b1;
                        discard_d = 1'b1;
                    end
                end else if (rx_pid == RX_BAD) begin
                    state_d = ST_OUT_BAD_WAIT;
                end
            end
            ST_OUT_BAD_WAIT: begin
                if (rx_pid == RX_IDLE) begin
                    state_d    = ST_NAK_SEND;
                    ret_d      = ST_IDLE;
                    clear_d    = 1'b1;
                    rx_error_d = 1'b1;
                end
            end
            ST_OUT_ACK: begin
                state_d = ST_OUT_ACK_WAIT;
            end
            ST_OUT_ACK_WAIT: begin
                if (tx_done) begin
                    state_d = discard_q ? ST_IDLE : ST_OUT_DRAIN;
                end
            end
            ST_OUT_DRAIN: begin
                if (buffer_occupancy == '0) begin
                    state_d = ST_IDLE;
                end else if ((rx_pid == RX_OUT) || (rx_pid == RX_IN)) begin
                    state_d    = ST_NAK_SEND;
                    ret_d      = ST_OUT_DRAIN;
                    rx_error_d = 1'b1;
                end
            end
            ST_IN_FILL: begin
                if (rx_pid == RX_IN) begin
                    cur_ep_d = rx_endpoint;
                    if ((rx_endpoint == tx_ep) && (buffer_occupancy == tx_packet_data_size)) begin
                        state_d = ST_IN_SEND;
                    end else begin
                        state_d    = ST_NAK_SEND;
                        ret_d      = ST_IN_FILL;
                        rx_error_d = 1'b1;
                    end
                end else if (rx_pid == RX_OUT) begin
                    state_d     = ST_OUT_SINK;
                    cur_ep_d    = rx_endpoint;
                    sink_data_d = 1'b0;
                end
            end
            ST_OUT_SINK: begin
                // Swallow the host's DATA packet, then refuse it once the bus goes idle.
                if (rx_pid == RX_DATA) begin
                    sink_data_d = 1'b1;
                end else if ((rx_pid == RX_IDLE) && sink_data_q) begin
                    state_d = ST_NAK_SEND;
                    ret_d   = ST_IN_FILL;
                end
            end
            ST_IN_SEND: begin
                state_d = ST_IN_STREAM;
            end
            ST_IN_STREAM: begin
                if (buffer_occupancy == '0) begin
                    state_d = ST_IN_TX_WAIT;
                end
            end
            ST_IN_TX_WAIT: begin
                if (tx_done) begin
                    state_d = ST_IN_WAIT_HS;
                    clear_d = 1'b1;
                end
            end
            ST_IN_WAIT_HS: begin
                if (rx_pid == RX_ACK) begin
                    state_d            = ST_IDLE;
                    in_tog_d[cur_ep_q] = ~in_tog_q[cur_ep_q];
                end else if (rx_pid == RX_NAK) begin
                    state_d    = ST_IDLE;
                    tx_error_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d         = ST_IDLE;
                    tx_error_d      = 1'b1;
                    timeout_error_d = 1'b1;
                end
            end
            ST_NAK_SEND: begin
                state_d = ST_NAK_WAIT;
            end
            ST_NAK_WAIT: begin
                if (tx_done) begin
                    state_d = ret_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_OUT_ACK:  tx_packet_d = TX_ACK;
            ST_NAK_SEND: tx_packet_d = TX_NAK;
            ST_IN_SEND:  tx_packet_d = TX_DATA;
            default:     tx_packet_d = TX_IDLE;
        endcase
        tx_data_toggle_d     = (state_d == ST_IN_SEND) ? in_tog_q[cur_ep_d] : 1'b0;
        d_mode_d             = is_tx_state(state_d);
        tx_transfer_active_d = is_tx_state(state_d);
        rx_transfer_active_d = (state_d == ST_OUT_WAIT_DATA) || (state_d == ST_OUT_RECV);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q              <= ST_IDLE;
            ret_q                <= ST_IDLE;
            cur_ep_q             <= '0;
            tog_q                <= 1'b0;
            discard_q            <= 1'b0;
            sink_data_q          <= 1'b0;
            out_tog_q            <= '0;
            in_tog_q             <= '0;
            rx_data_ready_q      <= 1'b0;
            rx_transfer_active_q <= 1'b0;
            rx_error_q           <= 1'b0;
            tx_transfer_active_q <= 1'b0;
            tx_error_q           <= 1'b0;
            rx_ep_out_q          <= '0;
            clear_q              <= 1'b0;
            tx_packet_q          <= TX_IDLE;
            tx_data_toggle_q     <= 1'b0;
            d_mode_q             <= 1'b0;
            timeout_error_q      <= 1'b0;
        end else begin
            state_q              <= state_d;
            ret_q                <= ret_d;
            cur_ep_q             <= cur_ep_d;
            tog_q                <= tog_d;
            discard_q            <= discard_d;
            sink_data_q          <= sink_data_d;
            out_tog_q            <= out_tog_d;
            in_tog_q             <= in_tog_d;
            rx_data_ready_q      <= rx_data_ready_d;
            rx_transfer_active_q <= rx_transfer_active_d;
            rx_error_q           <= rx_error_d;
            tx_transfer_active_q <= tx_transfer_active_d;
            tx_error_q           <= tx_error_d;
            rx_ep_out_q          <= rx_ep_out_d;
            clear_q              <= clear_d;
            tx_packet_q          <= tx_packet_d;
            tx_data_toggle_q     <= tx_data_toggle_d;
            d_mode_q             <= d_mode_d;
            timeout_error_q      <= timeout_error_d;
        end
    end

    assign rx_data_ready      = rx_data_ready_q;
    assign rx_transfer_active = rx_transfer_active_q;
    assign rx_error           = rx_error_q;
    assign tx_transfer_active = tx_transfer_active_q;
    assign tx_error           = tx_error_q;
    assign rx_ep_out          = rx_ep_out_q;
    assign clear              = clear_q;
    assign tx_packet          = tx_packet_q;
    assign tx_data_toggle     = tx_data_toggle_q;
    assign d_mode             = d_mode_q;
    assign timeout_error      = timeout_error_q;

endmodule

// File: doc/usb_proto_ctrl_mep.md
Name: usb_proto_ctrl_mep

Overview:
- Next-generation USB endpoint protocol controller that enforces OUT/IN transfer sequences across NUM_EP endpoints.
- Sits between the USB RX/TX blocks, the shared data buffer and the AHB-Lite slave.
- Adds three things over the single-endpoint controller: per-endpoint DATA0/DATA1 toggle tracking, a parametrised packet-size width, and a host-response timeout.
- All outputs are registered, decoded from the next state.

Parameters:
- EP_W, 1, endpoint address width; NUM_EP = 2**EP_W.
- SZ_W, 7, width of the byte-count and occupancy buses (max packet 2**SZ_W-1).
- TIMEOUT_CYC, 255, cycles to wait for host DATA or handshake before declaring a timeout.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; one clock, asynchronous, active-low.
- rx_packet  in  3  RX PID: 0 IDLE, 1 DATA, 2 OUT, 3 IN, 4 ACK, 5 NAK, 6 BAD.
- rx_endpoint  in  EP_W  endpoint number, valid while rx_packet is OUT or IN.
- rx_data_toggle  in  1  DATA0=0 / DATA1=1, valid while rx_packet is DATA.
- tx_done  in  1  TX finished its packet (1-cycle pulse).
- buffer_reserved  in  1  AHB is loading the buffer for an IN transfer.
- tx_ep  in  EP_W  endpoint the AHB load targets.
- tx_packet_data_size  in  SZ_W  bytes AHB intends to send.
- buffer_occupancy  in  SZ_W  bytes currently in buffer.
- rx_data_ready, rx_transfer_active, rx_error, tx_transfer_active, tx_error  out  1 each  AHB status.
- rx_ep_out  out  EP_W  endpoint of the last accepted OUT data.
- clear  out  1  buffer flush pulse.
- tx_packet  out  2  TX PID: 0 IDLE, 1 DATA, 2 ACK, 3 NAK.
- tx_data_toggle  out  1  DATA0/1 for TX, valid with tx_packet=DATA.
- d_mode  out  1  1 = TX drives the bus.
- timeout_error  out  1  sticky; set on host timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, all toggle bits 0, counter 0. Reset mid-transfer aborts to IDLE and clears the toggles.
- Register file: out_tog[NUM_EP] holds the expected OUT toggle; in_tog[NUM_EP] holds the next IN toggle. cur_ep is latched on an OUT or IN token.
- Sticky flags: rx_error, tx_error and timeout_error are cleared on entry to OUT_WAIT_DATA or IN_FILL. rx_data_ready holds until the next OUT token.
- IDLE:
  - OUT -> OUT_WAIT_DATA.
  - IN, or BAD -> NAK_SEND.
  - buffer_reserved -> IN_FILL.
  - Priority order: OUT, IN, BAD, buffer_reserved.
- OUT_WAIT_DATA (rx_transfer_active=1): DATA -> OUT_RECV, latching the toggle. Timeout -> IDLE with rx_error=1 and timeout_error=1.
- OUT_RECV (rx_transfer_active=1):
  - IDLE with toggle == out_tog[cur_ep] -> OUT_ACK; rx_data_ready=1, rx_ep_out=cur_ep, out_tog[cur_ep] flips.
  - IDLE with toggle mismatch (retransmission) -> OUT_ACK with clear=1 for one cycle; no rx_data_ready, toggle unchanged.
  - BAD -> OUT_BAD_WAIT.
- OUT_BAD_WAIT: on IDLE -> NAK_SEND with clear=1.
- OUT_ACK: tx_packet=ACK for one cycle, d_mode=1, tx_transfer_active=1 -> OUT_ACK_WAIT.
- OUT_ACK_WAIT: on tx_done -> OUT_DRAIN (or IDLE if the data was discarded).
- OUT_DRAIN (d_mode=0):
  - occupancy==0 -> IDLE.
  - OUT or IN token -> NAK_SEND with rx_error=1; return to OUT_DRAIN after tx_done.
- IN_FILL:
  - IN with rx_endpoint==tx_ep and occupancy==tx_packet_data_size -> IN_SEND.
  - IN otherwise -> NAK_SEND.
  - OUT -> wait for DATA then IDLE (OUT_SINK), then NAK_SEND.
- IN_SEND: tx_packet=DATA and tx_data_toggle=in_tog[cur_ep] for one cycle -> IN_STREAM.
- IN_STREAM: occupancy==0 -> IN_TX_WAIT.
- IN_TX_WAIT: on tx_done -> IN_WAIT_HS (counter starts).
- IN_WAIT_HS (clear=1 on entry):
  - ACK -> flip in_tog[cur_ep], then IDLE.
  - NAK -> tx_error=1, then IDLE.
  - Timeout -> tx_error=1, timeout_error=1, then IDLE; toggle unchanged.
- NAK_SEND: tx_packet=NAK for one cycle, d_mode=1 -> NAK_WAIT.
- NAK_WAIT: on tx_done -> return state.
- d_mode and tx_transfer_active are 1 in every TX-driving state.
- Timeout counter:
  - Cleared on each state change.
  - Increments each cycle in OUT_WAIT_DATA and IN_WAIT_HS.
  - Fires when count == TIMEOUT_CYC-1.
  - A token arriving on the same cycle as expiry wins over the timeout.
- Widths: size and occupancy compare at SZ_W bits; an equality test only, no arithmetic.

Optional Feature:
- Macro: USB_PROTO_TIMEOUT_EN.
- Defined: timeout counter and timeout_error behave as above.
- Undefined: no counter; OUT_WAIT_DATA and IN_WAIT_HS wait indefinitely; timeout_error is tied to 0.

Decomposition:
- Package usb_proto_pkg holds:
  - rx PID localparams/enum (3-bit);
  - tx PID enum (2-bit);
  - the controller state enum.
- One natural sub-module: proto_timeout_cnt, a clear/enable counter with a rollover flag, parametrised by TIMEOUT_CYC.

Test Plan:
- OUT ep1, DATA0, IDLE, then occupancy 8->0 -> ACK sent, rx_data_ready=1, rx_ep_out=1, out_tog[1]=1, return to IDLE.
- Repeat the same OUT ep1 with DATA0 -> ACK sent, clear pulse, rx_data_ready not reasserted, out_tog[1] stays 1.
- buffer_reserved, tx_ep=0, size=16, occupancy=16, IN ep0 -> tx_packet=DATA with toggle 0; host ACK -> in_tog[0]=1; second transfer sends toggle 1.
- IN ep1 while tx_ep=0 is loaded -> NAK; state stays in the fill path; rx_error=1.
- OUT ep0, DATA, BAD, IDLE -> clear pulse, NAK sent, rx_error=1.
- With USB_PROTO_TIMEOUT_EN: after IN data, no handshake for 255 cycles -> tx_error=1, timeout_error=1, in_tog unchanged, state IDLE.
